// File: rtl/alu_seq_pkg.sv
// Shared widths, opcodes, state encoding and command payload for the ALU
// command sequencer.
package alu_seq_pkg;

  localparam int unsigned OPERAND_W = 3;
  localparam int unsigned RESULT_W  = 5;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
  localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
  localparam logic [SEL_W-1:0] OP_MUL = 2'b10;
  localparam logic [SEL_W-1:0] OP_REM = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OPERAND_W-1:0] num1;
    logic [OPERAND_W-1:0] num2;
    logic [SEL_W-1:0]     sel;
  } cmd_t;

  // Saturating increment for the error counter
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) begin
      return v;
    end
    return v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pushes while full are dropped regardless of a
// same-cycle pop; flags and count are registered.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  cmd_t                     data_i,
  output cmd_t                     head_c_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ready_q, ready_d;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // Pointer, occupancy and flag update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
    ready_d = !full_d;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ready_q  <= ready_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign ready_o  = ready_q;
  assign count_o  = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: buffers commands, issues them to a combinational
// ALU through registered operands, and returns captured results on a
// valid/ready response stream.
// Optional build macro ALU_SEQ_ERR_CNT_EN adds an 8-bit saturating
// divide-by-zero counter on output err_count.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned OPERAND_W = alu_seq_pkg::OPERAND_W,
  parameter int unsigned RESULT_W  = alu_seq_pkg::RESULT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPERAND_W-1:0] cmd_num1,
  input  logic [OPERAND_W-1:0] cmd_num2,
  input  logic [1:0]           cmd_sel,
  output logic [OPERAND_W-1:0] alu_num1,
  output logic [OPERAND_W-1:0] alu_num2,
  output logic [1:0]           alu_sel,
  input  logic [RESULT_W-1:0]  alu_result,
  input  logic                 alu_zero_flag,
  input  logic                 alu_div_by_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RESULT_W-1:0]  rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_div_by_zero,
  output logic                 busy
`ifdef ALU_SEQ_ERR_CNT_EN
  ,
  output logic [7:0]           err_count
`endif
);

  import alu_seq_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] alu_num1_q, alu_num1_d;
  logic [OPERAND_W-1:0] alu_num2_q, alu_num2_d;
  logic [1:0]           alu_sel_q, alu_sel_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [RESULT_W-1:0]  rsp_result_q, rsp_result_d;
  logic                 rsp_zero_q, rsp_zero_d;
  logic                 rsp_dbz_q, rsp_dbz_d;
  logic                 busy_q, busy_d;

  cmd_t                 fifo_wdata;
  cmd_t                 fifo_head;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_ready;
  logic [CNT_W-1:0]     fifo_count;

  assign fifo_wdata.num1 = cmd_num1;
  assign fifo_wdata.num2 = cmd_num2;
  assign fifo_wdata.sel  = cmd_sel;
  assign fifo_push       = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .pop_i    (fifo_pop),
    .data_i   (fifo_wdata),
    .head_c_o (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .ready_o  (fifo_ready),
    .count_o  (fifo_count)
  );

  // Next-state, issue and response capture
  always_comb begin
    state_d      = state_q;
    fifo_pop     = 1'b0;
    alu_num1_d   = alu_num1_q;
    alu_num2_d   = alu_num2_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_dbz_d    = rsp_dbz_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          alu_num1_d = fifo_head.num1;
          alu_num2_d = fifo_head.num2;
          alu_sel_d  = fifo_head.sel;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero_flag;
        rsp_dbz_d    = alu_div_by_zero;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered view of "active or work pending" after this edge
    busy_d = (state_d != IDLE) || fifo_push || (fifo_count > CNT_W'(fifo_pop));
  end

  // State, ALU operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_num1_q   <= '0;
      alu_num2_q   <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_dbz_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_num1_q   <= alu_num1_d;
      alu_num2_q   <= alu_num2_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_dbz_q    <= rsp_dbz_d;
      busy_q       <= busy_d;
    end
  end

`ifdef ALU_SEQ_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Count divide-by-zero results at the capture edge, saturating
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == ISSUE) && alu_div_by_zero) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  // Error counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign cmd_ready       = fifo_ready;
  assign alu_num1        = alu_num1_q;
  assign alu_num2        = alu_num2_q;
  assign alu_sel         = alu_sel_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_div_by_zero = rsp_dbz_q;
  assign busy            = busy_q;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts operation commands over a valid/ready stream and buffers them in a small FIFO.
- Issues each command to the combinational ALU through registered operand/select outputs, captures result and flags, then presents them on a valid/ready response stream.
- Sits between the top-level operand entry/control logic and the ALU instance.

Parameters:
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- OPERAND_W, 3: operand width; must match the ALU.
- RESULT_W, 5: result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_num1  in  OPERAND_W  first operand.
- cmd_num2  in  OPERAND_W  second operand.
- cmd_sel  in  2  00 add, 01 sub, 10 mul, 11 rem.
- alu_num1  out  OPERAND_W  registered operand to ALU.
- alu_num2  out  OPERAND_W  registered operand to ALU.
- alu_sel  out  2  registered select to ALU.
- alu_result  in  RESULT_W  ALU result.
- alu_zero_flag  in  1  ALU zero flag.
- alu_div_by_zero  in  1  ALU divide-by-zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  RESULT_W  captured result.
- rsp_zero  out  1  captured zero flag.
- rsp_div_by_zero  out  1  captured divide-by-zero flag.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- One clock (clk); synchronous active-high reset (rst), effective on the rising edge where rst=1.
- Reset values: all outputs 0 except cmd_ready=1. FIFO is emptied, state goes to IDLE.
- Reset mid-operation discards the in-flight command and all queued commands; no response is produced for them.
- FIFO:
  - cmd_ready = (count != DEPTH), driven from registered count.
  - Push when cmd_valid && cmd_ready.
  - A push while full is never accepted, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
- State machine:
  - IDLE: if FIFO not empty, pop the head into alu_num1/alu_num2/alu_sel and go to ISSUE. Otherwise hold.
  - ISSUE: one settle cycle for the ALU. At the end of the cycle, register alu_result, alu_zero_flag and alu_div_by_zero into the rsp_* outputs, set rsp_valid=1, and go to RESP.
  - RESP: hold rsp_valid and rsp_* stable until rsp_valid && rsp_ready. On that edge clear rsp_valid and go to IDLE.
- alu_* outputs hold their last issued values outside ISSUE; they are 0 after reset.
- Latency: a command accepted on edge E into an empty FIFO with state IDLE gives rsp_valid=1 after edge E+2.
- Throughput: at most one response per 3 cycles.
- rsp_div_by_zero and rsp_zero are passed through exactly as the ALU reports them; the sequencer applies no masking.
- Response order equals command order.

Optional Feature:
- ALU_SEQ_ERR_CNT_EN.
- Defined: adds output err_count (out, 8 bits).
  - Increments on the ISSUE capture edge when alu_div_by_zero=1.
  - Saturates at 255.
  - Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package alu_seq_pkg holds:
  - OPERAND_W=3, RESULT_W=5.
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_REM=2'b11.
  - State encoding IDLE/ISSUE/RESP.
  - Command struct {num1, num2, sel}.
- One sub-module, alu_cmd_fifo: synchronous FIFO with push/pop/full/empty/count.
- The FSM and response register stay in alu_cmd_sequencer.

Test Plan:
- Basic add/mul/rem through a real ALU instance, rsp_ready=1:
  - cmd (3,2,00) -> rsp_result=5, rsp_zero=0, rsp_valid 2 cycles after acceptance.
  - cmd (3,5,10) -> 15.
  - cmd (7,3,11) -> 1.
- Divide by zero: cmd (7,0,11) -> rsp_div_by_zero=1 from the ALU. With ALU_SEQ_ERR_CNT_EN defined, err_count=1 after the capture edge.
- Backpressure and full:
  - Hold rsp_ready=0 and push 5 back-to-back commands (2,1,00)..(6,1,00).
  - Expect all 5 accepted, then cmd_ready=0 with count=4, and rsp_result=3 held stable.
  - Release rsp_ready -> results 3,4,5,6,7 in order.
- Zero result: cmd (4,2,11) -> rsp_result=0, rsp_zero=1, rsp_div_by_zero=0.
- Reset mid-operation: assert rst for one cycle while in RESP with 2 queued commands.
  - Next cycle: rsp_valid=0, cmd_ready=1, busy=0.
  - No stale responses afterwards.
- Saturation (ALU_SEQ_ERR_CNT_EN defined): issue 260 rem-by-zero commands -> err_count=255.
